// File: rtl/alu_result_buffer.sv
// alu_result_buffer: 2-entry FIFO between the ALU result mux and writeback, tagging each result with a zero flag.
module alu_result_buffer #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [2:0]       in_op,
  input  logic [TAGW-1:0]  in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [2:0]       out_op,
  output logic [TAGW-1:0]  out_tag,
  output logic [1:0]       count,
  output logic [15:0]      retired
);
  localparam int EW = WIDTH + 1 + 3 + TAGW;
  logic [EW-1:0] mem_q [2];
  logic          wp_q, rp_q;
  logic [1:0]    cnt_q, cnt_d;
  logic [15:0]   ret_q;
  logic          push, pop;
  // in_ready depends only on registered occupancy, so no path from out_ready
  assign in_ready  = cnt_q < 2'd2;
  assign out_valid = cnt_q != 2'd0;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = cnt_q;
  assign retired   = ret_q;
  assign {out_result, out_zero, out_op, out_tag} = out_valid ? mem_q[rp_q] : '0;
  always_comb begin
    cnt_d = flush ? 2'd0 : cnt_q + 2'(push) - 2'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
      ret_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
      if (flush) begin
        wp_q <= 1'b0;
        rp_q <= 1'b0;
      end else begin
        if (push) begin
          mem_q[wp_q] <= {in_result, ~|in_result, in_op, in_tag};
          wp_q        <= ~wp_q;
        end
        if (pop) begin
          rp_q  <= ~rp_q;
          ret_q <= ret_q + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: directed stimulus with a scoreboard queue checked by an independent negedge monitor.
module tb_alu_result_buffer;
  localparam int W = 32;
  localparam int T = 5;
  typedef logic [W+1+3+T-1:0] ent_t;
  logic         clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic [W-1:0] in_result = '0;
  logic [2:0]   in_op = '0;
  logic [T-1:0] in_tag = '0;
  logic         in_ready, out_valid, out_zero;
  logic [W-1:0] out_result;
  logic [2:0]   out_op;
  logic [T-1:0] out_tag;
  logic [1:0]   count;
  logic [15:0]  retired;
  ent_t         q[$];
  int           mcnt = 0;
  logic [15:0]  mret = '0;
  int           n_chk = 0, n_pass = 0;
  bit           pu, po, hold_v = 0;
  ent_t         hold_e, cur;

  alu_result_buffer #(.WIDTH(W), .TAGW(T)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_op(in_op), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_op(out_op), .out_tag(out_tag),
    .count(count), .retired(retired));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // reference occupancy / retire model, updated on the same edge as the DUT
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      mcnt = 0;
      mret = '0;
    end else if (flush) begin
      q.delete();
      mcnt = 0;
    end else begin
      pu = in_valid && mcnt < 2;
      po = mcnt != 0 && out_ready;
      if (po) mret = mret + 16'd1;
      if (pu) q.push_back({in_result, in_result == '0, in_op, in_tag});
      mcnt = mcnt + int'(pu) - int'(po);
    end
  end

  always @(negedge clk) begin
    cur = {out_result, out_zero, out_op, out_tag};
    if (rst_n) begin
      chk("count", 64'(count), 64'(mcnt));
      chk("out_valid", 64'(out_valid), 64'(mcnt != 0));
      chk("in_ready", 64'(in_ready), 64'(mcnt < 2));
      chk("retired", 64'(retired), 64'(mret));
      if (mcnt == 0) chk("empty_data", 64'(cur), 64'(0));
      if (hold_v) chk("hold_stable", 64'(cur), 64'(hold_e));
      if (out_valid && out_ready && !flush) begin
        if (q.size() == 0) chk("sb_underflow", 64'(1), 64'(0));
        else chk("sb_head", 64'(cur), 64'(q.pop_front()));
      end
      hold_v = out_valid && !out_ready && !flush;
      hold_e = cur;
    end else hold_v = 0;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] r, input logic [2:0] o, input logic [T-1:0] t);
    in_valid  = v;
    in_result = r;
    in_op     = o;
    in_tag    = t;
  endtask

  initial begin
    repeat (2) cyc();
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_retired", 64'(retired), 64'(0));
    chk("rst_data", 64'({out_result, out_zero, out_op, out_tag}), 64'(0));
    rst_n = 1;
    cyc();
    // single push, first edge after reset, no bypass
    drive(1, 32'h5, 3'b010, 5'd7);
    #1 chk("no_bypass", 64'(out_valid), 64'(0));
    cyc();
    drive(0, '0, '0, '0);
    chk("sp_valid", 64'(out_valid), 64'(1));
    chk("sp_result", 64'(out_result), 64'h5);
    chk("sp_zero", 64'(out_zero), 64'(0));
    chk("sp_op", 64'(out_op), 64'(2));
    chk("sp_tag", 64'(out_tag), 64'(7));
    chk("sp_count", 64'(count), 64'(1));
    out_ready = 1;
    cyc();
    out_ready = 0;
    chk("sp_retired", 64'(retired), 64'(1));
    // fill and backpressure; third push with 0x33 must be dropped
    drive(1, 32'hA, 3'd1, 5'd1);
    cyc();
    drive(1, 32'h0, 3'd4, 5'd2);
    cyc();
    chk("fill_count", 64'(count), 64'(2));
    chk("fill_in_ready", 64'(in_ready), 64'(0));
    drive(1, 32'h33, 3'd5, 5'd3);
    cyc();
    drive(0, '0, '0, '0);
    chk("fill_ignored", 64'(count), 64'(2));
    chk("fill_head", 64'(out_result), 64'hA);
    out_ready = 1;
    cyc();
    chk("fill_head2", 64'(out_result), 64'h0);
    chk("fill_zero", 64'(out_zero), 64'(1));
    cyc();
    out_ready = 0;
    chk("fill_empty", 64'(count), 64'(0));
    chk("fill_retired", 64'(retired), 64'(3));
    // simultaneous push and pop at count 1
    drive(1, 32'h11, 3'd6, 5'd4);
    cyc();
    drive(1, 32'h22, 3'd7, 5'd5);
    out_ready = 1;
    cyc();
    drive(0, '0, '0, '0);
    out_ready = 0;
    chk("pp_count", 64'(count), 64'(1));
    chk("pp_head", 64'(out_result), 64'h22);
    chk("pp_retired", 64'(retired), 64'(4));
    out_ready = 1;
    cyc();
    out_ready = 0;
    // flush beats push and pop
    drive(1, 32'h44, 3'd0, 5'd6);
    cyc();
    drive(1, 32'h55, 3'd1, 5'd7);
    cyc();
    chk("fl_pre_count", 64'(count), 64'(2));
    drive(1, 32'h66, 3'd2, 5'd8);
    flush = 1;
    out_ready = 1;
    cyc();
    flush = 0;
    out_ready = 0;
    drive(0, '0, '0, '0);
    chk("fl_count", 64'(count), 64'(0));
    chk("fl_out_valid", 64'(out_valid), 64'(0));
    chk("fl_retired", 64'(retired), 64'(5));
    drive(1, 32'h77, 3'd3, 5'd9);
    cyc();
    drive(0, '0, '0, '0);
    chk("fl_after", 64'(out_result), 64'h77);
    out_ready = 1;
    cyc();
    out_ready = 0;
    chk("fl_after_ret", 64'(retired), 64'(6));
    // async reset between edges at count 2
    drive(1, 32'h88, 3'd4, 5'd10);
    cyc();
    drive(1, 32'h99, 3'd5, 5'd11);
    cyc();
    drive(0, '0, '0, '0);
    #2 rst_n = 0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'(0));
    chk("ar_count", 64'(count), 64'(0));
    chk("ar_retired", 64'(retired), 64'(0));
    chk("ar_in_ready", 64'(in_ready), 64'(1));
    chk("ar_data", 64'(out_result), 64'(0));
    cyc();
    rst_n = 1;
    // pointer wrap over 5 push/pop pairs
    drive(1, 32'h100, 3'd1, 5'd12);
    cyc();
    out_ready = 1;
    for (int i = 1; i <= 5; i++) begin
      drive(1, 32'h100 + i, 3'(i), 5'(i));
      cyc();
      chk("wrap_head", 64'(out_result), 64'(32'h100 + i));
    end
    drive(0, '0, '0, '0);
    cyc();
    out_ready = 0;
    chk("wrap_retired", 64'(retired), 64'(6));
    chk("wrap_empty", 64'(count), 64'(0));
    // stream to 0xFFFF retirements, then one more to wrap
    drive(1, 32'h0, 3'd0, 5'd0);
    cyc();
    out_ready = 1;
    for (int i = 1; i <= 65529; i++) begin
      drive(1, 32'(i), 3'(i), 5'(i));
      cyc();
    end
    drive(0, '0, '0, '0);
    out_ready = 0;
    chk("rw_ffff", 64'(retired), 64'hFFFF);
    chk("rw_count", 64'(count), 64'(1));
    out_ready = 1;
    cyc();
    out_ready = 0;
    chk("rw_wrap", 64'(retired), 64'(0));
    chk("rw_empty", 64'(count), 64'(0));
    repeat (2) cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
